display_page_ctrl: RTL and testbench

Sequencer for the clock's 4-digit display page selection. It debounces the raw page button and runs a two-page state machine: HOME shows digits C1–C4, ALT shows C5–C8. An auto-return timer brings the display back to HOME. Its `page_sel` output drives the select input of the digit-set mux that sits between the time counters and the 7-segment scanner.

---
 rtl/display_page_ctrl.sv | 116 +++++++++++
 tb/tb_display_page_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/display_page_ctrl.sv
// Display page sequencer: debounced page button toggles HOME/ALT, force_home overrides.
// Optional auto-return to HOME after TIMEOUT_SEC ticks when DISP_AUTO_RETURN_EN is defined.
module display_page_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned TIMEOUT_SEC     = 10
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn_raw,
  input  logic tick_1hz,
  input  logic force_home,
  output logic page_sel,
  output logic page_changed
);

  localparam logic [0:0] ST_HOME = 1'b0;
  localparam logic [0:0] ST_ALT  = 1'b1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             btn_db;
  logic             btn_db_d;
  logic [CNT_W-1:0] db_cnt;
  logic             press;
  logic             timeout;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             page_changed_nxt;

  // Synchronizer and debounce: btn_db follows s2 only after DEBOUNCE_CYCLES stable cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      s1       <= btn_raw;
      s2       <= s1;
      btn_db_d <= btn_db;
      if (s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

`ifdef DISP_AUTO_RETURN_EN
  localparam int unsigned SEC_W = 8;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIMEOUT_SEC - 1);

  logic [SEC_W-1:0] sec_cnt;
  logic [SEC_W-1:0] sec_cnt_nxt;

  assign timeout = tick_1hz && (sec_cnt == SEC_LAST);

  // Second counter only runs in ALT; any exit or HOME residency parks it at 0.
  always_comb begin
    sec_cnt_nxt = sec_cnt;
    if (state_nxt == ST_HOME || state == ST_HOME) begin
      sec_cnt_nxt = '0;
    end else if (tick_1hz) begin
      sec_cnt_nxt = sec_cnt + SEC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sec_cnt <= '0;
    end else begin
      sec_cnt <= sec_cnt_nxt;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = tick_1hz ^ (TIMEOUT_SEC == 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_HOME;
      page_changed <= 1'b0;
    end else begin
      state        <= state_nxt;
      page_changed <= page_changed_nxt;
    end
  end

  // Priority: force_home, then press, then timeout; coincident events collapse to one move.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOME: begin
        if (!force_home && press) state_nxt = ST_ALT;
      end
      ST_ALT: begin
        if (force_home || press || timeout) state_nxt = ST_HOME;
      end
      default: state_nxt = ST_HOME;
    endcase
    page_changed_nxt = (state_nxt != state);
  end

  assign page_sel = state[0];

endmodule

// File: tb/tb_display_page_ctrl.sv
// Directed bench for display_page_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_SEC=3.
module tb_display_page_ctrl;

  logic CLK;
  logic RST_N;
  logic btn_raw;
  logic tick_1hz;
  logic force_home;
  logic page_sel;
  logic page_changed;

  int n_total = 0;
  int n_pass  = 0;

  display_page_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20),
    .TIMEOUT_SEC(3)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .btn_raw(btn_raw),
    .tick_1hz(tick_1hz),
    .force_home(force_home),
    .page_sel(page_sel),
    .page_changed(page_changed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Clean press: toggle lands after edge 7, then release and let it debounce back to 0.
  task automatic press_btn();
    btn_raw = 1'b1;
    step(7);
    btn_raw = 1'b0;
    step(8);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(2);
  endtask

  initial begin
    RST_N      = 1'b0;
    btn_raw    = 1'b0;
    tick_1hz   = 1'b0;
    force_home = 1'b0;
    step(2);
    chk("rst_sel", page_sel, 1'b0);
    chk("rst_chg", page_changed, 1'b0);
    RST_N = 1'b1;
    step(3);
    chk("post_rst_sel", page_sel, 1'b0);
    chk("post_rst_chg", page_changed, 1'b0);

    // Clean press held 20 cycles
    btn_raw = 1'b1;
    step(6);
    chk("clean_e6_sel", page_sel, 1'b0);
    chk("clean_e6_chg", page_changed, 1'b0);
    step(1);
    chk("clean_e7_sel", page_sel, 1'b1);
    chk("clean_e7_chg", page_changed, 1'b1);
    step(1);
    chk("clean_e8_sel", page_sel, 1'b1);
    chk("clean_e8_chg", page_changed, 1'b0);
    step(12);
    btn_raw = 1'b0;
    step(10);
    chk("release_sel", page_sel, 1'b1);
    chk("release_chg", page_changed, 1'b0);

    // Second clean press returns to HOME
    btn_raw = 1'b1;
    step(7);
    chk("press2_sel", page_sel, 1'b0);
    chk("press2_chg", page_changed, 1'b1);
    step(1);
    chk("press2_chg_off", page_changed, 1'b0);
    step(10);
    btn_raw = 1'b0;
    step(10);

    // Bouncy press: high 3, low 1, high 10
    btn_raw = 1'b1;
    step(3);
    btn_raw = 1'b0;
    step(1);
    btn_raw = 1'b1;
    step(2);
    chk("bounce_mid_sel", page_sel, 1'b0);
    step(4);
    chk("bounce_e10_sel", page_sel, 1'b0);
    step(1);
    chk("bounce_e11_sel", page_sel, 1'b1);
    chk("bounce_e11_chg", page_changed, 1'b1);
    step(1);
    chk("bounce_e12_chg", page_changed, 1'b0);
    step(2);
    btn_raw = 1'b0;
    step(10);
    chk("bounce_once_sel", page_sel, 1'b1);

    // Auto-return ticks in ALT
    pulse_tick();
    pulse_tick();
    chk("tick2_sel", page_sel, 1'b1);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
`ifdef DISP_AUTO_RETURN_EN
    chk("tick3_sel", page_sel, 1'b0);
    chk("tick3_chg", page_changed, 1'b1);
    step(2);
    press_btn();
    chk("reenter_alt_sel", page_sel, 1'b1);
`else
    chk("tick3_sel", page_sel, 1'b1);
    chk("tick3_chg", page_changed, 1'b0);
    step(2);
    for (int i = 0; i < 7; i++) pulse_tick();
    chk("tick10_sel", page_sel, 1'b1);
`endif

    // force_home from ALT, press during it is lost
    force_home = 1'b1;
    step(1);
    chk("force_sel", page_sel, 1'b0);
    chk("force_chg", page_changed, 1'b1);
    btn_raw = 1'b1;
    step(7);
    chk("force_press_sel", page_sel, 1'b0);
    chk("force_press_chg", page_changed, 1'b0);
    btn_raw = 1'b0;
    step(8);
    chk("force_held_sel", page_sel, 1'b0);
    force_home = 1'b0;
    step(2);
    chk("force_drop_sel", page_sel, 1'b0);
    press_btn();
    chk("after_force_sel", page_sel, 1'b1);

    // Press completion coincides with third tick in ALT
    pulse_tick();
    pulse_tick();
    btn_raw = 1'b1;
    step(6);
    chk("coinc_pre_sel", page_sel, 1'b1);
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    chk("coinc_sel", page_sel, 1'b0);
    chk("coinc_chg", page_changed, 1'b1);
    step(1);
    chk("coinc_sel_hold", page_sel, 1'b0);
    chk("coinc_chg_off", page_changed, 1'b0);
    step(4);
    btn_raw = 1'b0;
    step(8);
    chk("coinc_settle_sel", page_sel, 1'b0);

    // Asynchronous reset mid-ALT
    press_btn();
    chk("pre_async_sel", page_sel, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_sel", page_sel, 1'b0);
    chk("async_rst_chg", page_changed, 1'b0);
    step(2);
    RST_N = 1'b1;
    step(3);
    chk("final_sel", page_sel, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
